// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified fetch/data memory arbiter.
package mem_arb_pkg;
    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    // Owner of the response that arrives one cycle after a grant.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D_RD = 2'd2,
        OWN_D_WR = 2'd3
    } resp_owner_t;
endpackage

// File: rtl/arb_streak_counter.sv
// Saturating count of consecutive data grants while fetch is waiting.
module arb_streak_counter #(
    parameter int MAX_D_STREAK = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_sat
);
    localparam int CW = (MAX_D_STREAK > 0) ? $clog2(MAX_D_STREAK + 1) : 1;
    localparam logic [CW-1:0] MAXV = CW'(MAX_D_STREAK);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr)
            r_cnt <= '0;
        else if (i_inc && (r_cnt != MAXV))
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_sat = (r_cnt == MAXV);
endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one 1-cycle-latency memory between fetch and data ports and
// steers each response back to the port that issued it.
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int MAX_D_STREAK = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_stall,
    output logic                if_valid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_ren,
    input  logic                d_wen,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_mask,
    output logic                d_stall,
    output logic                d_valid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_ren,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_mask,
    input  logic [DATA_W-1:0]   mem_rdata
);
    logic        w_d_req, w_d_wr, w_sat, w_grant_if, w_grant_d;
    resp_owner_t r_owner;
    logic [DATA_W-1:0] r_if_hold, r_d_hold;

    assign w_d_req = d_ren | d_wen;
    assign w_d_wr  = d_wen;          // both strobes high is treated as a store

    // Nothing is granted while in reset, so no store can reach memory.
    assign w_grant_d  = ~rst & w_d_req & (~if_req | ~w_sat);
    assign w_grant_if = ~rst & if_req & ~w_grant_d;

    assign if_stall = ~rst & if_req  & ~w_grant_if;
    assign d_stall  = ~rst & w_d_req & ~w_grant_d;

    arb_streak_counter #(.MAX_D_STREAK(MAX_D_STREAK)) u_streak (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_grant_d & if_req),
        .i_clr (~if_req | w_grant_if),
        .o_sat (w_sat)
    );

    always_comb begin
        mem_addr  = '0;
        mem_ren   = 1'b0;
        mem_wen   = 1'b0;
        mem_wdata = '0;
        mem_mask  = '0;
        if (w_grant_d) begin
            mem_addr  = d_addr;
            mem_ren   = ~w_d_wr;
            mem_wen   = w_d_wr;
            mem_wdata = d_wdata;
            mem_mask  = d_mask;
        end else if (w_grant_if) begin
            mem_addr  = if_addr;
            mem_ren   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_owner <= OWN_NONE;
        else if (w_grant_d)
            r_owner <= w_d_wr ? OWN_D_WR : OWN_D_RD;
        else if (w_grant_if)
            r_owner <= OWN_IF;
        else
            r_owner <= OWN_NONE;
    end

    // Memory data is live during the response cycle; the hold registers keep
    // the last response visible until the next one.
    assign if_valid = ~rst & (r_owner == OWN_IF);
    assign d_valid  = ~rst & ((r_owner == OWN_D_RD) | (r_owner == OWN_D_WR));
    assign if_rdata = if_valid ? mem_rdata : r_if_hold;
    assign d_rdata  = d_valid ? ((r_owner == OWN_D_RD) ? mem_rdata : '0) : r_d_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_if_hold <= '0;
            r_d_hold  <= '0;
        end else begin
            if (if_valid) r_if_hold <= if_rdata;
            if (d_valid)  r_d_hold  <= d_rdata;
        end
    end
endmodule
